// File: rtl/segasys1_sndcmd_queue.sv
// Sound command queue between the main Z80 sound-request strobe and the sound CPU.
// Commands are buffered in a small FIFO and delivered one at a time as an NMI pulse plus
// a held command byte. Each delivery ends on an acknowledge or after a timeout.
module segasys1_sndcmd_queue #(
  parameter int unsigned DEPTH_LOG2 = 2,
  parameter int unsigned NMI_LEN    = 16,
  parameter int unsigned GAP_LEN    = 64,
  parameter int unsigned TMO_LEN    = 65535
) (
  input  logic                  CLK40M,
  input  logic                  RESET_N,
  input  logic                  CMD_WR,
  input  logic [7:0]            CMD_DI,
  input  logic                  SND_ACK,
  input  logic                  PAUSE_N,
  output logic [7:0]            SND_CMD,
  output logic                  SND_NMI,
  output logic [DEPTH_LOG2:0]   FIFO_LVL,
  output logic                  OVF,
  output logic [7:0]            TMO_CNT,
  output logic                  BUSY
);

  localparam int unsigned DEPTH   = 1 << DEPTH_LOG2;
  localparam int unsigned PTR_W   = DEPTH_LOG2;
  localparam int unsigned LVL_W   = DEPTH_LOG2 + 1;
  localparam int unsigned MAX_NG  = (NMI_LEN > GAP_LEN) ? NMI_LEN : GAP_LEN;
  localparam int unsigned MAX_LEN = (MAX_NG > TMO_LEN) ? MAX_NG : TMO_LEN;
  localparam int unsigned CNT_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_NMI  = 3'd2;
  localparam logic [2:0] ST_WAIT = 3'd3;
  localparam logic [2:0] ST_GAP  = 3'd4;

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [2:0]       state_q;
  logic [2:0]       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             nmi_d;
  logic [7:0]       cmd_d;
  logic [7:0]       tmo_d;
  logic             pop_c;
  logic             full_c;
  logic             push_c;
  logic [LVL_W-1:0] lvl_d;

  // Delivery FSM next-state; frozen entirely while PAUSE_N is low
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    nmi_d   = SND_NMI;
    cmd_d   = SND_CMD;
    tmo_d   = TMO_CNT;
    pop_c   = 1'b0;
    if (PAUSE_N) begin
      case (state_q)
        ST_IDLE: begin
          if (FIFO_LVL != '0) state_d = ST_LOAD;
        end
        ST_LOAD: begin
          cmd_d   = mem[rd_ptr];
          cnt_d   = CNT_W'(NMI_LEN - 1);
          nmi_d   = 1'b1;
          state_d = ST_NMI;
        end
        ST_NMI: begin
          if (SND_ACK) begin
            pop_c   = 1'b1;
            nmi_d   = 1'b0;
            cnt_d   = CNT_W'(GAP_LEN - 1);
            state_d = ST_GAP;
          end else if (cnt_q == '0) begin
            nmi_d   = 1'b0;
            cnt_d   = CNT_W'(TMO_LEN - 1);
            state_d = ST_WAIT;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ST_WAIT: begin
          if (SND_ACK) begin
            pop_c   = 1'b1;
            cnt_d   = CNT_W'(GAP_LEN - 1);
            state_d = ST_GAP;
          end else if (cnt_q == '0) begin
            pop_c   = 1'b1;
            if (TMO_CNT != 8'hFF) tmo_d = TMO_CNT + 8'd1;
            cnt_d   = CNT_W'(GAP_LEN - 1);
            state_d = ST_GAP;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ST_GAP: begin
          if (cnt_q == '0) state_d = ST_IDLE;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
        default: begin
          state_d = ST_IDLE;
          nmi_d   = 1'b0;
        end
      endcase
    end
  end

  // FIFO push/level; a same-cycle pop frees the slot before the push is judged
  always_comb begin
    full_c = (FIFO_LVL == LVL_W'(DEPTH));
    push_c = CMD_WR && (!full_c || pop_c);
    lvl_d  = FIFO_LVL + LVL_W'(push_c) - LVL_W'(pop_c);
  end

  // FIFO storage, not reset; validity is tracked by the level and pointers
  always_ff @(posedge CLK40M) begin
    if (push_c) mem[wr_ptr] <= CMD_DI;
  end

  // State, counters and all registered outputs
  always_ff @(posedge CLK40M or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      SND_CMD  <= '0;
      SND_NMI  <= 1'b0;
      FIFO_LVL <= '0;
      OVF      <= 1'b0;
      TMO_CNT  <= '0;
      BUSY     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      SND_CMD  <= cmd_d;
      SND_NMI  <= nmi_d;
      TMO_CNT  <= tmo_d;
      FIFO_LVL <= lvl_d;
      BUSY     <= (state_d != ST_IDLE);
      if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (CMD_WR && full_c && !pop_c) OVF <= 1'b1;
    end
  end

endmodule

// File: tb/tb_segasys1_sndcmd_queue.sv
// Directed bench for segasys1_sndcmd_queue with a command scoreboard.
module tb_segasys1_sndcmd_queue;

  localparam int unsigned NMI_LEN = 16;
  localparam int unsigned GAP_LEN = 64;
  localparam int unsigned TMO_LEN = 8;

  logic       CLK40M;
  logic       RESET_N;
  logic       CMD_WR;
  logic [7:0] CMD_DI;
  logic       SND_ACK;
  logic       PAUSE_N;
  logic [7:0] SND_CMD;
  logic       SND_NMI;
  logic [2:0] FIFO_LVL;
  logic       OVF;
  logic [7:0] TMO_CNT;
  logic       BUSY;

  int checks   = 0;
  int failures = 0;
  logic [7:0] sb [$];

  segasys1_sndcmd_queue #(
    .DEPTH_LOG2(2), .NMI_LEN(NMI_LEN), .GAP_LEN(GAP_LEN), .TMO_LEN(TMO_LEN)
  ) dut (
    .CLK40M(CLK40M), .RESET_N(RESET_N), .CMD_WR(CMD_WR), .CMD_DI(CMD_DI),
    .SND_ACK(SND_ACK), .PAUSE_N(PAUSE_N), .SND_CMD(SND_CMD), .SND_NMI(SND_NMI),
    .FIFO_LVL(FIFO_LVL), .OVF(OVF), .TMO_CNT(TMO_CNT), .BUSY(BUSY)
  );

  initial CLK40M = 1'b0;
  always #5 CLK40M = ~CLK40M;

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK40M);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    CMD_WR = 1'b1;
    CMD_DI = b;
    tick();
    CMD_WR = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    RESET_N = 1'b0;
    #1;
    chk({tag, "_cmd"}, 32'(SND_CMD), 0);
    chk({tag, "_nmi"}, 32'(SND_NMI), 0);
    chk({tag, "_lvl"}, 32'(FIFO_LVL), 0);
    chk({tag, "_ovf"}, 32'(OVF), 0);
    chk({tag, "_tmo"}, 32'(TMO_CNT), 0);
    chk({tag, "_busy"}, 32'(BUSY), 0);
    sb.delete();
    tick();
    tick();
    #3;
    RESET_N = 1'b1;
    tick();
  endtask

  // Waits for SND_NMI high, then checks the presented byte against the scoreboard head
  task automatic wait_nmi(input string tag, input int max, output int n);
    logic [7:0] exp;
    n = 0;
    while (SND_NMI !== 1'b1 && n < max) begin
      tick();
      n++;
    end
    chk({tag, "_nmi"}, 32'(SND_NMI), 1);
    exp = (sb.size() != 0) ? sb.pop_front() : 8'h00;
    chk({tag, "_cmd"}, 32'(SND_CMD), 32'(exp));
  endtask

  // ACK sampled k edges after the NMI rise edge
  task automatic ack_after(input int k);
    for (int j = 0; j < k - 1; j++) tick();
    SND_ACK = 1'b1;
    tick();
    SND_ACK = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int max);
    int n;
    n = 0;
    while ((BUSY !== 1'b0 || FIFO_LVL !== 3'd0) && n < max) begin
      tick();
      n++;
    end
    chk({tag, "_idle"}, 32'(BUSY), 0);
  endtask

  initial begin
    int n;
    int w;
    int expired;
    logic fell;
    logic seen;
    CMD_WR = 1'b0; CMD_DI = 8'h00; SND_ACK = 1'b0; PAUSE_N = 1'b1; RESET_N = 1'b1;
    tick();
    do_reset("rst0");

    // Single push with ACK after 5 NMI cycles
    push(8'h81);
    sb.push_back(8'h81);
    chk("t1_lvl_n", 32'(FIFO_LVL), 1);
    chk("t1_nmi_n", 32'(SND_NMI), 0);
    tick();
    chk("t1_busy_n1", 32'(BUSY), 1);
    chk("t1_nmi_n1", 32'(SND_NMI), 0);
    tick();
    wait_nmi("t1", 0, n);
    for (int j = 0; j < 4; j++) tick();
    chk("t1_nmi_hold", 32'(SND_NMI), 1);
    SND_ACK = 1'b1;
    tick();
    SND_ACK = 1'b0;
    chk("t1_nmi_ack", 32'(SND_NMI), 0);
    chk("t1_lvl_ack", 32'(FIFO_LVL), 0);
    for (int j = 0; j < int'(GAP_LEN) - 1; j++) tick();
    chk("t1_busy_gap", 32'(BUSY), 1);
    tick();
    chk("t1_busy_idle", 32'(BUSY), 0);
    chk("t1_cmd_held", 32'(SND_CMD), 32'h81);
    chk("t1_tmo", 32'(TMO_CNT), 0);

    // Full FIFO with push and ACK-pop in the same cycle
    do_reset("rst1");
    for (int i = 0; i < 4; i++) begin
      push(8'hA0 + 8'(i));
      sb.push_back(8'hA0 + 8'(i));
    end
    chk("t3_lvl_full", 32'(FIFO_LVL), 4);
    wait_nmi("t3_a0", 10, n);
    CMD_WR = 1'b1; CMD_DI = 8'hA4; SND_ACK = 1'b1;
    tick();
    CMD_WR = 1'b0; SND_ACK = 1'b0;
    sb.push_back(8'hA4);
    chk("t3_lvl_same", 32'(FIFO_LVL), 4);
    chk("t3_ovf", 32'(OVF), 0);
    chk("t3_nmi_low", 32'(SND_NMI), 0);
    for (int i = 0; i < 4; i++) begin
      wait_nmi("t3_dl", int'(GAP_LEN) + 10, n);
      ack_after(2);
    end
    wait_idle("t3", 200);
    chk("t3_ovf_end", 32'(OVF), 0);
    chk("t3_lvl_end", 32'(FIFO_LVL), 0);

    // Five back-to-back pushes into a 4-deep FIFO
    do_reset("rst2");
    for (int i = 0; i < 5; i++) begin
      push(8'h10 + 8'(i));
      if (i < 4) sb.push_back(8'h10 + 8'(i));
    end
    chk("t2_ovf", 32'(OVF), 1);
    chk("t2_lvl", 32'(FIFO_LVL), 4);
    for (int i = 0; i < 4; i++) begin
      wait_nmi("t2_dl", int'(GAP_LEN) + 10, n);
      ack_after(3);
    end
    wait_idle("t2", 200);
    seen = 1'b0;
    for (int j = 0; j < 100; j++) begin
      tick();
      if (SND_NMI) seen = 1'b1;
    end
    chk("t2_no_extra", 32'(seen), 0);
    chk("t2_ovf_sticky", 32'(OVF), 1);

    // Pause for 100 cycles mid-NMI, with a push and an ignored ACK during the pause
    do_reset("rst3");
    push(8'h55);
    sb.push_back(8'h55);
    wait_nmi("t5", 10, n);
    w = 1;
    fell = 1'b0;
    for (int i = 0; i < 130; i++) begin
      PAUSE_N = !(i >= 3 && i < 103);
      CMD_WR  = (i == 50);
      CMD_DI  = 8'h66;
      SND_ACK = (i == 60);
      tick();
      if (i == 50) chk("t5_push_lvl", 32'(FIFO_LVL), 2);
      if (i == 60) chk("t5_ack_ignored", 32'(SND_NMI), 1);
      if (!fell) begin
        if (SND_NMI) w++;
        else fell = 1'b1;
      end
    end
    PAUSE_N = 1'b1; CMD_WR = 1'b0; SND_ACK = 1'b0;
    sb.push_back(8'h66);
    chk("t5_width", 32'(w), NMI_LEN + 100);
    wait_nmi("t5_next", 100, n);
    chk("t5_tmo", 32'(TMO_CNT), 1);
    ack_after(1);

    // Timeout path: NMI width, pop latency, gap to next NMI
    do_reset("rst4");
    push(8'h31);
    push(8'h32);
    sb.push_back(8'h31);
    sb.push_back(8'h32);
    wait_nmi("t4", 10, n);
    for (int k = 1; k <= 24; k++) begin
      tick();
      if (k == 15) chk("t4_nmi_last", 32'(SND_NMI), 1);
      if (k == 16) chk("t4_nmi_fall", 32'(SND_NMI), 0);
      if (k == 23) chk("t4_lvl_pre", 32'(FIFO_LVL), 2);
      if (k == 24) begin
        chk("t4_lvl_pop", 32'(FIFO_LVL), 1);
        chk("t4_tmo", 32'(TMO_CNT), 1);
      end
    end
    wait_nmi("t4_next", int'(GAP_LEN) + 20, n);
    chk("t4_gap", 32'(n), GAP_LEN + 2);
    ack_after(1);

    // Saturation after 300 timeouts
    do_reset("rst5");
    expired = 0;
    for (int i = 0; i < 300; i++) begin
      push(8'(i));
      n = 0;
      while ((BUSY !== 1'b0 || FIFO_LVL !== 3'd0) && n < 200) begin
        tick();
        n++;
      end
      if (n >= 200) expired++;
      if (i == 199) chk("t6_tmo_200", 32'(TMO_CNT), 200);
    end
    chk("t6_bound", 32'(expired), 0);
    chk("t6_tmo_sat", 32'(TMO_CNT), 255);

    // Reset during WAIT with three entries queued
    do_reset("rst6");
    push(8'h41);
    push(8'h42);
    push(8'h43);
    sb.push_back(8'h41);
    wait_nmi("t7", 10, n);
    for (int j = 0; j < 20; j++) tick();
    chk("t7_wait_nmi", 32'(SND_NMI), 0);
    chk("t7_wait_busy", 32'(BUSY), 1);
    chk("t7_wait_lvl", 32'(FIFO_LVL), 3);
    do_reset("t7_rst");
    seen = 1'b0;
    for (int j = 0; j < 100; j++) begin
      tick();
      if (SND_NMI) seen = 1'b1;
    end
    chk("t7_no_replay", 32'(seen), 0);
    chk("t7_lvl", 32'(FIFO_LVL), 0);
    chk("t7_busy", 32'(BUSY), 0);
    push(8'h44);
    sb.push_back(8'h44);
    wait_nmi("t7_new", 10, n);
    ack_after(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/segasys1_sndcmd_queue.md
# segasys1_sndcmd_queue

Buffers sound commands written by the main Z80 (OUT to ports $14/$18) and delivers them one at a time to the sound CPU. Each delivery is an NMI pulse plus a held command byte, and the next command waits for an acknowledge or a timeout. It sits between the main-CPU sound-request strobe (SNDRQ/SNDNO) and the sound CPU's command latch/NMI input, so that back-to-back writes from the main CPU are not lost.

## Interface
Parameters:
- DEPTH_LOG2, 2, FIFO depth is 2^DEPTH_LOG2 entries (default 4).
- NMI_LEN, 16, SND_NMI high time in CLK40M cycles (≥1).
- GAP_LEN, 64, minimum idle cycles between deliveries (≥1).
- TMO_LEN, 65535, cycles to wait for SND_ACK before discarding (≥1).

Ports:
- CLK40M  in  1  system clock; all logic on rising edge.
- RESET_N  in  1  reset, asynchronous, active-low.
- CMD_WR  in  1  one-cycle push strobe (main-CPU SNDRQ).
- CMD_DI  in  8  command byte sampled with CMD_WR (SNDNO).
- SND_ACK  in  1  one-cycle strobe: sound CPU has read the command latch.
- PAUSE_N  in  1  low freezes the delivery FSM and its counters.
- SND_CMD  out  8  command byte currently presented to the sound CPU.
- SND_NMI  out  1  NMI request to the sound CPU.
- FIFO_LVL  out  DEPTH_LOG2+1  entries queued, including the one in delivery.
- OVF  out  1  sticky: a push was dropped because the FIFO was full.
- TMO_CNT  out  8  count of timed-out deliveries, saturates at 255.
- BUSY  out  1  high whenever the FSM is not in IDLE.

## Operation
- Reset (RESET_N low, asynchronous): all outputs 0; FIFO empty; FSM in IDLE; counters 0.
- FIFO: synchronous, read and write pointers wrap modulo 2^DEPTH_LOG2. The head entry stays in the FIFO until its delivery completes.
- Push: CMD_WR=1 with level below full → CMD_DI written, level +1.
- Push while full: CMD_DI dropped, OVF←1. If a pop happens in the same cycle, the pop frees a slot first, the push is accepted and OVF is unchanged.
- Pushes are accepted regardless of PAUSE_N and FSM state.
- FSM states:
  - IDLE: level≠0 → LOAD.
  - LOAD (one cycle): SND_CMD←head; counter←NMI_LEN-1 → NMI.
  - NMI: SND_NMI=1. SND_ACK → pop, SND_NMI←0, counter←GAP_LEN-1 → GAP. Counter 0 → SND_NMI←0, counter←TMO_LEN-1 → WAIT. Otherwise decrement.
  - WAIT: SND_ACK → pop, counter←GAP_LEN-1 → GAP. Counter 0 → pop, TMO_CNT+1 (saturating), counter←GAP_LEN-1 → GAP. Otherwise decrement.
  - GAP: counter 0 → IDLE, otherwise decrement.
- SND_ACK in IDLE, LOAD or GAP is ignored.
- SND_CMD holds its last value after the pop, through GAP and IDLE, so the sound CPU can re-read it. It changes only in LOAD.
- PAUSE_N low: FSM state, counter and SND_NMI hold their values. SND_ACK and timeout are not evaluated. FIFO pushes continue.
- BUSY = (state≠IDLE). FIFO_LVL and BUSY are registered.

## Timing
- CMD_WR sampled at edge N into an empty FIFO with the FSM in IDLE:
  - FIFO_LVL=1 after edge N.
  - LOAD entered at edge N+1.
  - SND_CMD valid and SND_NMI=1 after edge N+2.
- Without ACK, SND_NMI is high for exactly NMI_LEN cycles.
- ACK sampled at edge M (in NMI or WAIT): pop and SND_NMI=0 after edge M; IDLE reached at edge M+GAP_LEN.
- No ACK: the pop happens NMI_LEN+TMO_LEN cycles after NMI entry.
- Back-to-back: next SND_NMI rises GAP_LEN+2 cycles after the pop edge.
- Reset asserted mid-delivery: SND_NMI drops asynchronously and the queue is flushed. No command is replayed after reset release.

## Test plan
- Single push of 0x81, ACK 5 cycles after NMI rises → SND_CMD=0x81 at N+2; NMI high 5 cycles; FIFO_LVL 1→0; TMO_CNT=0.
- Five pushes 0x10–0x14 in five consecutive cycles (DEPTH_LOG2=2), ACK each → delivered 0x10–0x13 in order; 0x14 dropped; OVF=1.
- Full FIFO with push and ACK-pop in the same cycle → push accepted, OVF stays 0, FIFO_LVL unchanged.
- No ACK, TMO_LEN=8 → NMI 16 cycles, pop 24 cycles after NMI entry, TMO_CNT=1, next entry delivered after the gap. 300 timeouts → TMO_CNT=255.
- PAUSE_N low for 100 cycles mid-NMI → SND_NMI stays high; total NMI width is NMI_LEN plus the pause length. A push during the pause → FIFO_LVL increments.
- RESET_N pulsed low during WAIT with 3 entries queued → all outputs 0 immediately; IDLE after release; no NMI until a new push.
